// File: rtl/decode_stage_pkg.sv
// Shared decode constants for the D stage: opcode/funct fields, exception codes,
// next-PC select encodings and register-use deadlines.
package decode_stage_pkg;

    localparam int unsigned NumRegs = 32;

    localparam logic [5:0] OpSpecial = 6'h00;
    localparam logic [5:0] OpJal     = 6'h03;
    localparam logic [5:0] OpBeq     = 6'h04;
    localparam logic [5:0] OpBne     = 6'h05;
    localparam logic [5:0] OpAddi    = 6'h08;
    localparam logic [5:0] OpAndi    = 6'h0c;
    localparam logic [5:0] OpOri     = 6'h0d;
    localparam logic [5:0] OpLui     = 6'h0f;
    localparam logic [5:0] OpCop0    = 6'h10;
    localparam logic [5:0] OpLb      = 6'h20;
    localparam logic [5:0] OpLh      = 6'h21;
    localparam logic [5:0] OpLw      = 6'h23;
    localparam logic [5:0] OpSb      = 6'h28;
    localparam logic [5:0] OpSh      = 6'h29;
    localparam logic [5:0] OpSw      = 6'h2b;

    localparam logic [5:0] FnJr      = 6'h08;
    localparam logic [5:0] FnSyscall = 6'h0c;
    localparam logic [5:0] FnMfhi    = 6'h10;
    localparam logic [5:0] FnMthi    = 6'h11;
    localparam logic [5:0] FnMflo    = 6'h12;
    localparam logic [5:0] FnMtlo    = 6'h13;
    localparam logic [5:0] FnMult    = 6'h18;
    localparam logic [5:0] FnMultu   = 6'h19;
    localparam logic [5:0] FnDiv     = 6'h1a;
    localparam logic [5:0] FnDivu    = 6'h1b;
    localparam logic [5:0] FnAdd     = 6'h20;
    localparam logic [5:0] FnSub     = 6'h22;
    localparam logic [5:0] FnAnd     = 6'h24;
    localparam logic [5:0] FnOr      = 6'h25;
    localparam logic [5:0] FnSlt     = 6'h2a;
    localparam logic [5:0] FnSltu    = 6'h2b;
    localparam logic [5:0] FnEret    = 6'h18;

    // COP0 sub-op lives in the rs field
    localparam logic [4:0] Cop0Mf = 5'h00;
    localparam logic [4:0] Cop0Mt = 5'h04;
    localparam logic [4:0] Cop0Co = 5'h10;

    localparam logic [1:0] TuseNow  = 2'd0;
    localparam logic [1:0] TuseAlu  = 2'd1;
    localparam logic [1:0] TuseMem  = 2'd2;
    localparam logic [1:0] TuseNone = 2'd3;

    typedef enum logic [4:0] {
        ExcNone    = 5'd0,
        ExcAdEL    = 5'd4,
        ExcAdES    = 5'd5,
        ExcSyscall = 5'd8,
        ExcRI      = 5'd10,
        ExcOv      = 5'd12
    } exc_code_e;

    typedef enum logic [2:0] {
        PcNext   = 3'd0,
        PcBranch = 3'd1,
        PcJal    = 3'd2,
        PcJr     = 3'd3,
        PcEret   = 3'd4
    } pc_sel_e;

    typedef enum logic [5:0] {
        InsNop, InsAdd, InsSub, InsAnd, InsOr, InsSlt, InsSltu,
        InsLui, InsAddi, InsAndi, InsOri,
        InsLb, InsLh, InsLw, InsSb, InsSh, InsSw,
        InsMult, InsMultu, InsDiv, InsDivu, InsMfhi, InsMflo, InsMthi, InsMtlo,
        InsBeq, InsBne, InsJal, InsJr, InsMfc0, InsMtc0, InsEret, InsSyscall,
        InsIllegal
    } instr_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_grf.sv
// 32x32 general register file: synchronous reset, one write port, two combinational reads.
// GRF_BYPASS_EN: when defined, a read of the register being written returns the write data.
module grf
    import decode_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_a_o,
    output logic [31:0] rdata_b_o
);

    logic [31:0] regs_q [NumRegs];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

`ifdef GRF_BYPASS_EN
    always_comb begin
        rdata_a_o = regs_q[raddr_a_i];
        rdata_b_o = regs_q[raddr_b_i];
        if (we_i && (waddr_i == raddr_a_i)) rdata_a_o = wdata_i;
        if (we_i && (waddr_i == raddr_b_i)) rdata_b_o = wdata_i;
        // $0 is hardwired, even against a same-cycle write
        if (raddr_a_i == 5'd0) rdata_a_o = 32'd0;
        if (raddr_b_i == 5'd0) rdata_b_o = 32'd0;
    end
`else
    always_comb begin
        rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : regs_q[raddr_a_i];
        rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : regs_q[raddr_b_i];
    end
`endif

endmodule

// File: rtl/decode_stage.sv
// MIPS D stage: register file, instruction decode, branch resolution, Tuse and ExcCode.
// Same-cycle write-to-read bypass in the register file is enabled by GRF_BYPASS_EN.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] D_in_PC,
    input  logic [31:0] D_in_W_PC,
    input  logic [31:0] D_in_instruction,
    input  logic [31:0] D_rs_trans,
    input  logic [31:0] D_rt_trans,
    input  logic [31:0] D_RegWD,
    input  logic [4:0]  D_RegWreg,
    input  logic        D_RegWrite,
    input  logic        D_in_IsDelay,
    input  logic [4:0]  D_in_F_ExcCode,
    output logic [31:0] D_out_PC,
    output logic [31:0] D_out_instruction,
    output logic [31:0] D_data_rs,
    output logic [31:0] D_data_rt,
    output logic [4:0]  D_addr_rt,
    output logic [4:0]  D_addr_rd,
    output logic [31:0] D_EXT_out,
    output logic [31:0] D_Shift_out,
    output logic        w_grf_we,
    output logic [4:0]  w_grf_addr,
    output logic [31:0] w_grf_wdata,
    output logic [31:0] w_inst_addr,
    output logic [2:0]  PC_sel,
    output logic [1:0]  Rs_Tuse,
    output logic [1:0]  Rt_Tuse,
    output logic        MDen,
    output logic        D_eret,
    output logic        IsBranch,
    output logic        D_out_IsDelay,
    output logic [4:0]  D_out_D_ExcCode
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm16;
    logic [31:0] imm_sext;
    logic [31:0] branch_target;
    logic [31:0] jal_target;
    logic [4:0]  exc_dec;
    instr_e      instr;

    assign opcode   = D_in_instruction[31:26];
    assign rs       = D_in_instruction[25:21];
    assign rt       = D_in_instruction[20:16];
    assign funct    = D_in_instruction[5:0];
    assign imm16    = D_in_instruction[15:0];
    assign imm_sext = sext16(imm16);

    assign branch_target = D_in_PC + 32'd4 + {imm_sext[29:0], 2'b00};
    assign jal_target    = {D_in_PC[31:28], D_in_instruction[25:0], 2'b00};

    assign D_out_PC          = D_in_PC;
    assign D_out_instruction = D_in_instruction;
    assign D_out_IsDelay     = D_in_IsDelay;
    assign D_addr_rt         = rt;
    assign D_addr_rd         = D_in_instruction[15:11];

    assign w_grf_we    = D_RegWrite;
    assign w_grf_addr  = D_RegWreg;
    assign w_grf_wdata = D_RegWD;
    assign w_inst_addr = D_in_W_PC;

    grf u_grf (
        .clk_i     (clk),
        .reset_i   (reset),
        .raddr_a_i (rs),
        .raddr_b_i (rt),
        .we_i      (D_RegWrite),
        .waddr_i   (D_RegWreg),
        .wdata_i   (D_RegWD),
        .rdata_a_o (D_data_rs),
        .rdata_b_o (D_data_rt)
    );

    always_comb begin
        instr = InsIllegal;
        case (opcode)
            OpSpecial: begin
                // Only the all-zero word is accepted as nop; other shift encodings are RI
                if (D_in_instruction == 32'd0) begin
                    instr = InsNop;
                end else begin
                    case (funct)
                        FnAdd:     instr = InsAdd;
                        FnSub:     instr = InsSub;
                        FnAnd:     instr = InsAnd;
                        FnOr:      instr = InsOr;
                        FnSlt:     instr = InsSlt;
                        FnSltu:    instr = InsSltu;
                        FnMult:    instr = InsMult;
                        FnMultu:   instr = InsMultu;
                        FnDiv:     instr = InsDiv;
                        FnDivu:    instr = InsDivu;
                        FnMfhi:    instr = InsMfhi;
                        FnMflo:    instr = InsMflo;
                        FnMthi:    instr = InsMthi;
                        FnMtlo:    instr = InsMtlo;
                        FnJr:      instr = InsJr;
                        FnSyscall: instr = InsSyscall;
                        default:   instr = InsIllegal;
                    endcase
                end
            end
            OpLui:  instr = InsLui;
            OpAddi: instr = InsAddi;
            OpAndi: instr = InsAndi;
            OpOri:  instr = InsOri;
            OpLb:   instr = InsLb;
            OpLh:   instr = InsLh;
            OpLw:   instr = InsLw;
            OpSb:   instr = InsSb;
            OpSh:   instr = InsSh;
            OpSw:   instr = InsSw;
            OpBeq:  instr = InsBeq;
            OpBne:  instr = InsBne;
            OpJal:  instr = InsJal;
            OpCop0: begin
                if (rs == Cop0Mf) begin
                    instr = InsMfc0;
                end else if (rs == Cop0Mt) begin
                    instr = InsMtc0;
                end else if ((rs == Cop0Co) && (funct == FnEret)) begin
                    instr = InsEret;
                end
            end
            default: instr = InsIllegal;
        endcase
    end

    always_comb begin
        PC_sel      = PcNext;
        Rs_Tuse     = TuseNone;
        Rt_Tuse     = TuseNone;
        MDen        = 1'b0;
        D_eret      = 1'b0;
        IsBranch    = 1'b0;
        D_Shift_out = 32'd0;
        D_EXT_out   = imm_sext;
        exc_dec     = ExcNone;
        case (instr)
            InsAdd, InsSub, InsAnd, InsOr, InsSlt, InsSltu: begin
                Rs_Tuse = TuseAlu;
                Rt_Tuse = TuseAlu;
            end
            InsAddi, InsLb, InsLh, InsLw: Rs_Tuse = TuseAlu;
            InsAndi, InsOri: begin
                Rs_Tuse   = TuseAlu;
                D_EXT_out = {16'd0, imm16};
            end
            InsLui: D_EXT_out = {imm16, 16'd0};
            InsSb, InsSh, InsSw: begin
                Rs_Tuse = TuseAlu;
                Rt_Tuse = TuseMem;
            end
            InsMult, InsMultu, InsDiv, InsDivu: begin
                Rs_Tuse = TuseAlu;
                Rt_Tuse = TuseAlu;
                MDen    = 1'b1;
            end
            InsMfhi, InsMflo: MDen = 1'b1;
            InsMthi, InsMtlo: begin
                Rs_Tuse = TuseAlu;
                MDen    = 1'b1;
            end
            InsBeq, InsBne: begin
                Rs_Tuse     = TuseNow;
                Rt_Tuse     = TuseNow;
                IsBranch    = 1'b1;
                D_Shift_out = branch_target;
                // Compare the forwarded operands, not the raw register reads
                if ((D_rs_trans == D_rt_trans) == (instr == InsBeq)) PC_sel = PcBranch;
            end
            InsJal: begin
                IsBranch    = 1'b1;
                D_Shift_out = jal_target;
                PC_sel      = PcJal;
            end
            InsJr: begin
                Rs_Tuse  = TuseNow;
                IsBranch = 1'b1;
                PC_sel   = PcJr;
            end
            InsMtc0: Rt_Tuse = TuseMem;
            InsEret: begin
                D_eret = 1'b1;
                PC_sel = PcEret;
            end
            InsSyscall: exc_dec = ExcSyscall;
            InsNop, InsMfc0: ;
            default: exc_dec = ExcRI;
        endcase
    end

    // A fetch-side exception always takes priority over anything found in decode
    assign D_out_D_ExcCode = (D_in_F_ExcCode != 5'd0) ? D_in_F_ExcCode : exc_dec;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed steps plus randomized instructions drawn from a table of
// per-instruction attributes, with a register-file model; honours GRF_BYPASS_EN.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] D_in_PC, D_in_W_PC, D_in_instruction, D_rs_trans, D_rt_trans, D_RegWD;
    logic [4:0]  D_RegWreg, D_in_F_ExcCode;
    logic        D_RegWrite, D_in_IsDelay;
    logic [31:0] D_out_PC, D_out_instruction, D_data_rs, D_data_rt, D_EXT_out, D_Shift_out;
    logic [31:0] w_grf_wdata, w_inst_addr;
    logic [4:0]  D_addr_rt, D_addr_rd, w_grf_addr, D_out_D_ExcCode;
    logic        w_grf_we, MDen, D_eret, IsBranch, D_out_IsDelay;
    logic [2:0]  PC_sel;
    logic [1:0]  Rs_Tuse, Rt_Tuse;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset), .D_in_PC(D_in_PC), .D_in_W_PC(D_in_W_PC),
        .D_in_instruction(D_in_instruction), .D_rs_trans(D_rs_trans), .D_rt_trans(D_rt_trans),
        .D_RegWD(D_RegWD), .D_RegWreg(D_RegWreg), .D_RegWrite(D_RegWrite),
        .D_in_IsDelay(D_in_IsDelay), .D_in_F_ExcCode(D_in_F_ExcCode), .D_out_PC(D_out_PC),
        .D_out_instruction(D_out_instruction), .D_data_rs(D_data_rs), .D_data_rt(D_data_rt),
        .D_addr_rt(D_addr_rt), .D_addr_rd(D_addr_rd), .D_EXT_out(D_EXT_out),
        .D_Shift_out(D_Shift_out), .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr),
        .w_grf_wdata(w_grf_wdata), .w_inst_addr(w_inst_addr), .PC_sel(PC_sel),
        .Rs_Tuse(Rs_Tuse), .Rt_Tuse(Rt_Tuse), .MDen(MDen), .D_eret(D_eret),
        .IsBranch(IsBranch), .D_out_IsDelay(D_out_IsDelay), .D_out_D_ExcCode(D_out_D_ExcCode)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] model [32];

    // Instruction formats used to build words from a table row
    localparam int FR = 0, FI = 1, FJ = 2, FC = 3, FE = 4, FN = 5;

    typedef struct {
        int         fmt;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] sub;
        int         ext;   // 0 sign, 1 zero, 2 upper
        int         tgt;   // 0 none, 1 branch, 2 jal
        int         pcs;   // 0 seq, 1 beq, 2 bne, 3 jal, 4 jr, 5 eret
        int         rs_t;
        int         rt_t;
        bit         md;
        int         exc;
    } row_t;

    row_t  rows[$];
    string names[$];

    task automatic add_row(input string n, input int fmt, input logic [5:0] op, fn,
                           input logic [4:0] sub, input int ext, tgt, pcs, rs_t, rt_t,
                           input bit md, input int exc);
        row_t r;
        r.fmt = fmt; r.op = op; r.fn = fn; r.sub = sub; r.ext = ext; r.tgt = tgt;
        r.pcs = pcs; r.rs_t = rs_t; r.rt_t = rt_t; r.md = md; r.exc = exc;
        rows.push_back(r);
        names.push_back(n);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] build(input row_t r, input logic [4:0] s, t, d,
                                          input logic [15:0] imm, input logic [25:0] idx);
        case (r.fmt)
            FR:      return {6'd0, s, t, d, imm[10:6], r.fn};
            FI:      return {r.op, s, t, imm};
            FJ:      return {r.op, idx};
            FC:      return {6'h10, r.sub, t, d, 11'd0};
            FE:      return 32'h4200_0018;
            default: return 32'd0;
        endcase
    endfunction

    // What a read port should show this cycle, given the model and the live write port
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef GRF_BYPASS_EN
        if (D_RegWrite && (D_RegWreg == a)) return D_RegWD;
`endif
        return model[a];
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
        D_in_instruction = ins;
        D_in_PC = pc;
        #1;
    endtask

    task automatic commit_write();
        @(posedge clk);
        if (D_RegWrite && (D_RegWreg != 5'd0)) model[D_RegWreg] = D_RegWD;
        #1;
    endtask

    initial begin
        row_t        r;
        int          k;
        logic [31:0] ins, pc, a, b, e_ext, e_sh, sx;
        logic [15:0] imm;
        logic [4:0]  fx, e_exc;
        logic [2:0]  e_ps;

        add_row("add", FR, 6'h00, 6'h20, 5'd0, 0, 0, 0, 1, 1, 0, 0);
        add_row("sub", FR, 6'h00, 6'h22, 5'd0, 0, 0, 0, 1, 1, 0, 0);
        add_row("and", FR, 6'h00, 6'h24, 5'd0, 0, 0, 0, 1, 1, 0, 0);
        add_row("or", FR, 6'h00, 6'h25, 5'd0, 0, 0, 0, 1, 1, 0, 0);
        add_row("slt", FR, 6'h00, 6'h2a, 5'd0, 0, 0, 0, 1, 1, 0, 0);
        add_row("sltu", FR, 6'h00, 6'h2b, 5'd0, 0, 0, 0, 1, 1, 0, 0);
        add_row("lui", FI, 6'h0f, 6'h00, 5'd0, 2, 0, 0, 3, 3, 0, 0);
        add_row("addi", FI, 6'h08, 6'h00, 5'd0, 0, 0, 0, 1, 3, 0, 0);
        add_row("andi", FI, 6'h0c, 6'h00, 5'd0, 1, 0, 0, 1, 3, 0, 0);
        add_row("ori", FI, 6'h0d, 6'h00, 5'd0, 1, 0, 0, 1, 3, 0, 0);
        add_row("lb", FI, 6'h20, 6'h00, 5'd0, 0, 0, 0, 1, 3, 0, 0);
        add_row("lh", FI, 6'h21, 6'h00, 5'd0, 0, 0, 0, 1, 3, 0, 0);
        add_row("lw", FI, 6'h23, 6'h00, 5'd0, 0, 0, 0, 1, 3, 0, 0);
        add_row("sb", FI, 6'h28, 6'h00, 5'd0, 0, 0, 0, 1, 2, 0, 0);
        add_row("sh", FI, 6'h29, 6'h00, 5'd0, 0, 0, 0, 1, 2, 0, 0);
        add_row("sw", FI, 6'h2b, 6'h00, 5'd0, 0, 0, 0, 1, 2, 0, 0);
        add_row("mult", FR, 6'h00, 6'h18, 5'd0, 0, 0, 0, 1, 1, 1, 0);
        add_row("multu", FR, 6'h00, 6'h19, 5'd0, 0, 0, 0, 1, 1, 1, 0);
        add_row("div", FR, 6'h00, 6'h1a, 5'd0, 0, 0, 0, 1, 1, 1, 0);
        add_row("divu", FR, 6'h00, 6'h1b, 5'd0, 0, 0, 0, 1, 1, 1, 0);
        add_row("mfhi", FR, 6'h00, 6'h10, 5'd0, 0, 0, 0, 3, 3, 1, 0);
        add_row("mflo", FR, 6'h00, 6'h12, 5'd0, 0, 0, 0, 3, 3, 1, 0);
        add_row("mthi", FR, 6'h00, 6'h11, 5'd0, 0, 0, 0, 1, 3, 1, 0);
        add_row("mtlo", FR, 6'h00, 6'h13, 5'd0, 0, 0, 0, 1, 3, 1, 0);
        add_row("beq", FI, 6'h04, 6'h00, 5'd0, 0, 1, 1, 0, 0, 0, 0);
        add_row("bne", FI, 6'h05, 6'h00, 5'd0, 0, 1, 2, 0, 0, 0, 0);
        add_row("jal", FJ, 6'h03, 6'h00, 5'd0, 0, 2, 3, 3, 3, 0, 0);
        add_row("jr", FR, 6'h00, 6'h08, 5'd0, 0, 0, 4, 0, 3, 0, 0);
        add_row("mfc0", FC, 6'h10, 6'h00, 5'd0, 0, 0, 0, 3, 3, 0, 0);
        add_row("mtc0", FC, 6'h10, 6'h00, 5'd4, 0, 0, 0, 3, 2, 0, 0);
        add_row("eret", FE, 6'h10, 6'h18, 5'd16, 0, 0, 5, 3, 3, 0, 0);
        add_row("syscall", FR, 6'h00, 6'h0c, 5'd0, 0, 0, 0, 3, 3, 0, 8);
        add_row("nop", FN, 6'h00, 6'h00, 5'd0, 0, 0, 0, 3, 3, 0, 0);
        add_row("ill_op3f", FI, 6'h3f, 6'h00, 5'd0, 0, 0, 0, 3, 3, 0, 10);
        add_row("ill_j", FI, 6'h02, 6'h00, 5'd0, 0, 0, 0, 3, 3, 0, 10);
        add_row("ill_slti", FI, 6'h0a, 6'h00, 5'd0, 0, 0, 0, 3, 3, 0, 10);
        add_row("ill_srl", FR, 6'h00, 6'h02, 5'd0, 0, 0, 0, 3, 3, 0, 10);
        add_row("ill_jalr", FR, 6'h00, 6'h09, 5'd0, 0, 0, 0, 3, 3, 0, 10);

        // Reset, with a write pending that must be discarded
        reset = 1'b1;
        D_in_PC = 32'h3000; D_in_W_PC = 32'h2ff0; D_in_instruction = 32'd0;
        D_rs_trans = 32'd0; D_rt_trans = 32'd0; D_in_IsDelay = 1'b0; D_in_F_ExcCode = 5'd0;
        D_RegWrite = 1'b1; D_RegWreg = 5'd7; D_RegWD = 32'h1111_2222;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        @(posedge clk); #1;
        reset = 1'b0;
        D_RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            drive({6'd0, 5'(i), 5'(31 - i), 16'd0}, 32'h3000);
            chk("reset_rs", D_data_rs, 32'd0);
            chk("reset_rt", D_data_rt, 32'd0);
        end

        // W-port write, then read back; trace outputs follow the port
        D_RegWrite = 1'b1; D_RegWreg = 5'd5; D_RegWD = 32'h1234_5678; D_in_W_PC = 32'h0000_3abc;
        #1;
        chk("trace_we", 32'(w_grf_we), 32'd1);
        chk("trace_addr", 32'(w_grf_addr), 32'd5);
        chk("trace_wdata", w_grf_wdata, 32'h1234_5678);
        chk("trace_pc", w_inst_addr, 32'h0000_3abc);
        commit_write();
        D_RegWrite = 1'b0;
        drive({6'd0, 5'd5, 5'd0, 16'd0}, 32'h3000);
        chk("wr5_rs", D_data_rs, 32'h1234_5678);
        D_RegWrite = 1'b1; D_RegWreg = 5'd0; D_RegWD = 32'hdead_beef;
        commit_write();
        D_RegWrite = 1'b0;
        drive({6'd0, 5'd0, 5'd0, 16'h0001}, 32'h3000);
        chk("wr0_rs", D_data_rs, 32'd0);

        // Same-cycle write/read of $8
        D_RegWrite = 1'b1; D_RegWreg = 5'd8; D_RegWD = 32'hcafe_f00d;
        drive(32'hac08_0000, 32'h3000);
        chk("same_cycle_rt8", D_data_rt, exp_read(5'd8));
        commit_write();
        D_RegWrite = 1'b0;
        #1;
        chk("after_write_rt8", D_data_rt, 32'hcafe_f00d);

        // Directed decode cases
        D_rs_trans = 32'd7; D_rt_trans = 32'd7;
        drive(32'h1022_0004, 32'h3000);
        chk("beq_eq_pcsel", 32'(PC_sel), 32'd1);
        chk("beq_target", D_Shift_out, 32'h3014);
        chk("beq_isbranch", 32'(IsBranch), 32'd1);
        D_rt_trans = 32'd8;
        #1;
        chk("beq_ne_pcsel", 32'(PC_sel), 32'd0);
        drive(32'h0c00_0c03, 32'h3008);
        chk("jal_pcsel", 32'(PC_sel), 32'd2);
        chk("jal_target", D_Shift_out, 32'h0000_300c);
        drive(32'h03e0_0008, 32'h3008);
        chk("jr_pcsel", 32'(PC_sel), 32'd3);
        chk("jr_rs_tuse", 32'(Rs_Tuse), 32'd0);
        drive(32'h3401_8000, 32'h3000);
        chk("ori_ext", D_EXT_out, 32'h0000_8000);
        drive(32'h2001_8000, 32'h3000);
        chk("addi_ext", D_EXT_out, 32'hffff_8000);
        drive(32'h3c01_1234, 32'h3000);
        chk("lui_ext", D_EXT_out, 32'h1234_0000);
        drive(32'h0000_000c, 32'h3000);
        chk("syscall_exc", 32'(D_out_D_ExcCode), 32'd8);
        drive(32'hfc00_0000, 32'h3000);
        chk("op3f_exc", 32'(D_out_D_ExcCode), 32'd10);
        D_in_F_ExcCode = 5'd4;
        drive(32'h0000_000c, 32'h3000);
        chk("fexc_priority", 32'(D_out_D_ExcCode), 32'd4);
        D_in_F_ExcCode = 5'd0;
        drive(32'h4200_0018, 32'h3000);
        chk("eret_flag", 32'(D_eret), 32'd1);
        chk("eret_pcsel", 32'(PC_sel), 32'd4);
        drive(32'h0022_0018, 32'h3000);
        chk("mult_mden", 32'(MDen), 32'd1);
        chk("mult_rs_tuse", 32'(Rs_Tuse), 32'd1);
        chk("mult_rt_tuse", 32'(Rt_Tuse), 32'd1);
        drive(32'hac22_0000, 32'h3000);
        chk("sw_rt_tuse", 32'(Rt_Tuse), 32'd2);

        // Randomized instructions against the attribute table and register model
        for (int it = 0; it < 400; it++) begin
            k = $urandom_range(0, rows.size() - 1);
            r = rows[k];
            ins = build(r, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                        26'($urandom));
            pc = $urandom() & 32'hffff_fffc;
            a = $urandom();
            b = ($urandom_range(0, 1) == 1) ? a : $urandom();
            fx = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            D_rs_trans = a; D_rt_trans = b; D_in_F_ExcCode = fx;
            D_in_IsDelay = 1'($urandom); D_in_W_PC = $urandom();
            D_RegWrite = 1'($urandom); D_RegWreg = 5'($urandom); D_RegWD = $urandom();
            drive(ins, pc);

            imm = ins[15:0];
            sx = {{16{imm[15]}}, imm};
            case (r.ext)
                1:       e_ext = {16'd0, imm};
                2:       e_ext = {imm, 16'd0};
                default: e_ext = sx;
            endcase
            case (r.tgt)
                1:       e_sh = pc + 32'd4 + (sx << 2);
                2:       e_sh = {pc[31:28], ins[25:0], 2'b00};
                default: e_sh = 32'd0;
            endcase
            case (r.pcs)
                1:       e_ps = (a == b) ? 3'd1 : 3'd0;
                2:       e_ps = (a != b) ? 3'd1 : 3'd0;
                3:       e_ps = 3'd2;
                4:       e_ps = 3'd3;
                5:       e_ps = 3'd4;
                default: e_ps = 3'd0;
            endcase
            e_exc = (fx != 5'd0) ? fx : 5'(r.exc);

            chk({names[k], ".rs_read"}, D_data_rs, exp_read(ins[25:21]));
            chk({names[k], ".rt_read"}, D_data_rt, exp_read(ins[20:16]));
            chk({names[k], ".addr_rt"}, 32'(D_addr_rt), 32'(ins[20:16]));
            chk({names[k], ".addr_rd"}, 32'(D_addr_rd), 32'(ins[15:11]));
            chk({names[k], ".out_pc"}, D_out_PC, pc);
            chk({names[k], ".out_instr"}, D_out_instruction, ins);
            chk({names[k], ".isdelay"}, 32'(D_out_IsDelay), 32'(D_in_IsDelay));
            chk({names[k], ".exc"}, 32'(D_out_D_ExcCode), 32'(e_exc));
            chk({names[k], ".ext"}, D_EXT_out, e_ext);
            chk({names[k], ".shift"}, D_Shift_out, e_sh);
            chk({names[k], ".trace_we"}, 32'(w_grf_we), 32'(D_RegWrite));
            chk({names[k], ".trace_addr"}, 32'(w_grf_addr), 32'(D_RegWreg));
            chk({names[k], ".trace_wdata"}, w_grf_wdata, D_RegWD);
            chk({names[k], ".trace_pc"}, w_inst_addr, D_in_W_PC);
            if (r.exc != 10) begin
                chk({names[k], ".pc_sel"}, 32'(PC_sel), 32'(e_ps));
                chk({names[k], ".rs_tuse"}, 32'(Rs_Tuse), 32'(r.rs_t));
                chk({names[k], ".rt_tuse"}, 32'(Rt_Tuse), 32'(r.rt_t));
                chk({names[k], ".mden"}, 32'(MDen), 32'(r.md));
                chk({names[k], ".eret"}, 32'(D_eret), (r.pcs == 5) ? 32'd1 : 32'd0);
                chk({names[k], ".isbranch"}, 32'(IsBranch),
                    (r.pcs >= 1 && r.pcs <= 4) ? 32'd1 : 32'd0);
            end
            commit_write();
        end

        // Reset clears everything and drops a simultaneous write; trace still follows inputs
        D_in_F_ExcCode = 5'd0;
        reset = 1'b1;
        D_RegWrite = 1'b1; D_RegWreg = 5'd9; D_RegWD = 32'h55aa_55aa;
        #1;
        chk("reset_trace_we", 32'(w_grf_we), 32'd1);
        chk("reset_trace_addr", 32'(w_grf_addr), 32'd9);
        @(posedge clk); #1;
        reset = 1'b0;
        D_RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        for (int i = 0; i < 32; i++) begin
            drive({6'd0, 5'(i), 5'(i), 16'd0}, 32'h3000);
            chk("rereset_rs", D_data_rs, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
